alu_rs_scheduler: RTL and testbench
===================================

ALU_RS_SCHEDULER -- requirements
Module: alu_rs_scheduler

Interface
REQ-001 SHALL have parameter RS_SIZE, default 8: number of reservation entries (power of two, 2..16).
REQ-002 SHALL have parameter TAG_W, default 5: width of destination/dependency tags.
REQ-003 SHALL have port clk_in  input  1  system clock; one clock, all state on rising edge.
REQ-004 SHALL have port rst_in  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port rdy_in  input  1  pause; low freezes all state and outputs.
REQ-006 SHALL have port flush_in  input  1  mispredict flush; discards all entries.
REQ-007 SHALL have ports disp_valid(1), disp_op(7), disp_Vi(32), disp_Qi(TAG_W), disp_Qi_busy(1), disp_Vj(32), disp_Qj(TAG_W), disp_Qj_busy(1), disp_imm(32), disp_rd(TAG_W), disp_pc(32), disp_itype(1), all inputs: one dispatched instruction.
REQ-008 SHALL have ports cdb0_valid(1), cdb0_tag(TAG_W), cdb0_val(32), cdb1_valid(1), cdb1_tag(TAG_W), cdb1_val(32), all inputs: two result broadcast buses.
REQ-009 SHALL have ports alu_op(7), alu_Vi(32), alu_Vj(32), alu_imm(32), alu_rd(5), alu_pc(32), alu_itype(1), all outputs, registered: issue bundle to the ALU.
REQ-010 SHALL have port full_out  output  1  no free entry (combinational from state).
REQ-011 SHALL have port count_out  output  $clog2(RS_SIZE)+1  occupied entry count (registered).

Function
REQ-012 Each entry SHALL hold busy, op, Vi, Qi, Qi_busy, Vj, Qj, Qj_busy, imm, rd, pc, itype.
REQ-013 Entry ready SHALL = busy & !Qi_busy & !Qj_busy.
REQ-014 Dispatch SHALL be accepted when disp_valid & !full_out & !flush_in; written into lowest-index free entry.
REQ-015 Dispatch while full_out=1 SHALL be ignored, no state change for that request.
REQ-016 Per edge, each busy operand whose tag matches a valid CDB SHALL capture that value and clear its busy bit; cdb0 SHALL win if both buses carry the same tag.
REQ-017 Dispatched operand with busy=1 whose tag matches a valid CDB in the same cycle SHALL be stored as value-ready (captured value, busy=0).
REQ-018 Issue SHALL select the lowest-index ready entry, as of state before the current edge; at most one issue per cycle.
REQ-019 On issue, outputs SHALL be loaded from the entry and the entry freed at the same edge; freed entry usable by dispatch next cycle.
REQ-020 With no ready entry, alu_op SHALL be 0 (ALU idle encoding); other alu_* outputs hold previous values.
REQ-021 Minimum latency: dispatch accepted at edge N with operands ready -> alu_op nonzero after edge N+1.
REQ-022 Operand woken by CDB at edge N -> entry eligible for issue at edge N+1 (no same-edge wake-and-issue).
REQ-023 count_out SHALL track +1 per accepted dispatch, -1 per issue, net 0 when both occur.
REQ-024 flush_in=1 (with rdy_in=1) SHALL clear all busy bits, set alu_op=0, count_out=0; overrides dispatch, wake-up and issue in that cycle.
REQ-025 rdy_in=0 SHALL hold every register, including alu_op, regardless of disp_valid, CDB or flush_in.
REQ-026 alu_rd SHALL be the low 5 bits of entry rd.

Reset
REQ-027 rst_in=1 at an edge SHALL clear all busy bits, alu_op=0, alu_Vi/Vj/imm/pc=0, alu_rd=0, alu_itype=0, count_out=0; full_out=0 after.
REQ-028 Reset SHALL take priority over rdy_in, flush_in and dispatch; reset mid-operation drops all entries.

Verification
REQ-029 Ready ADD dispatch (Vi=5,Vj=7,rd=3) at edge 1 -> after edge 2 alu_op=ADD, alu_Vi=5, alu_Vj=7, alu_rd=3; after edge 3 alu_op=0.
REQ-030 Dispatch Qi_busy tag 9; cdb1 tag 9 val 0x20 two cycles later -> issue one edge after broadcast with alu_Vi=0x20.
REQ-031 Fill 8 non-ready entries -> full_out=1, count_out=8; 9th dispatch ignored; one wake-up/issue -> full_out=0 next cycle.
REQ-032 Entries 2 and 5 woken same edge -> entry 2 issues first, entry 5 next cycle.
REQ-033 flush_in with 4 entries and simultaneous disp_valid -> count_out=0, alu_op=0, dispatch dropped.
REQ-034 rdy_in low 3 cycles with ready entry and CDB activity -> no issue, no capture; resumes identically when rdy_in returns high.

Source files
------------

// File: rtl/alu_rs_scheduler.sv
// ALU reservation station scheduler.
//
// Holds up to RS_SIZE dispatched ALU instructions. Operands still waiting
// for a producer capture their values from two result broadcast buses.
// Each cycle the lowest-index entry whose operands are both present is
// issued to the ALU.
//
// Ports
//   clk_in, rst_in        clock, synchronous active-high reset
//   rdy_in                pause: low freezes every register
//   flush_in              mispredict flush: drops all entries
//   disp_*                one dispatched instruction (disp_valid qualifies)
//   cdb0_*, cdb1_*        result broadcast buses (tag/value pairs)
//   alu_*                 registered issue bundle; alu_op == 0 means idle
//   full_out              no free entry (combinational from state)
//   count_out             registered occupied-entry count
module alu_rs_scheduler #(
    parameter int RS_SIZE = 8,
    parameter int TAG_W   = 5
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       rdy_in,
    input  logic                       flush_in,
    input  logic                       disp_valid,
    input  logic [6:0]                 disp_op,
    input  logic [31:0]                disp_Vi,
    input  logic [TAG_W-1:0]           disp_Qi,
    input  logic                       disp_Qi_busy,
    input  logic [31:0]                disp_Vj,
    input  logic [TAG_W-1:0]           disp_Qj,
    input  logic                       disp_Qj_busy,
    input  logic [31:0]                disp_imm,
    input  logic [TAG_W-1:0]           disp_rd,
    input  logic [31:0]                disp_pc,
    input  logic                       disp_itype,
    input  logic                       cdb0_valid,
    input  logic [TAG_W-1:0]           cdb0_tag,
    input  logic [31:0]                cdb0_val,
    input  logic                       cdb1_valid,
    input  logic [TAG_W-1:0]           cdb1_tag,
    input  logic [31:0]                cdb1_val,
    output logic [6:0]                 alu_op,
    output logic [31:0]                alu_Vi,
    output logic [31:0]                alu_Vj,
    output logic [31:0]                alu_imm,
    output logic [4:0]                 alu_rd,
    output logic [31:0]                alu_pc,
    output logic                       alu_itype,
    output logic                       full_out,
    output logic [$clog2(RS_SIZE):0]   count_out
);

    localparam int IDX_W = $clog2(RS_SIZE);
    localparam int CNT_W = IDX_W + 1;

    // Entry state
    logic [RS_SIZE-1:0] busy_reg;
    logic [RS_SIZE-1:0] qi_busy_reg;
    logic [RS_SIZE-1:0] qj_busy_reg;
    logic [RS_SIZE-1:0] itype_reg;
    logic [6:0]         op_reg  [RS_SIZE];
    logic [31:0]        vi_reg  [RS_SIZE];
    logic [31:0]        vj_reg  [RS_SIZE];
    logic [31:0]        imm_reg [RS_SIZE];
    logic [31:0]        pc_reg  [RS_SIZE];
    logic [TAG_W-1:0]   qi_reg  [RS_SIZE];
    logic [TAG_W-1:0]   qj_reg  [RS_SIZE];
    logic [TAG_W-1:0]   rd_reg  [RS_SIZE];

    // Per-entry status and wake-up
    logic [RS_SIZE-1:0] ready;
    logic [RS_SIZE-1:0] wake_i;
    logic [RS_SIZE-1:0] wake_j;
    logic [31:0]        wake_vi [RS_SIZE];
    logic [31:0]        wake_vj [RS_SIZE];

    genvar gi;
    generate
        for (gi = 0; gi < RS_SIZE; gi++) begin : g_entry
            logic hit_i0, hit_i1, hit_j0, hit_j1;
            assign hit_i0 = cdb0_valid && (cdb0_tag == qi_reg[gi]);
            assign hit_i1 = cdb1_valid && (cdb1_tag == qi_reg[gi]);
            assign hit_j0 = cdb0_valid && (cdb0_tag == qj_reg[gi]);
            assign hit_j1 = cdb1_valid && (cdb1_tag == qj_reg[gi]);
            // Ready is evaluated on pre-edge state, so an operand woken at
            // this edge only makes its entry eligible on the following one.
            assign ready[gi]   = busy_reg[gi] & ~qi_busy_reg[gi] & ~qj_busy_reg[gi];
            assign wake_i[gi]  = busy_reg[gi] & qi_busy_reg[gi] & (hit_i0 | hit_i1);
            assign wake_j[gi]  = busy_reg[gi] & qj_busy_reg[gi] & (hit_j0 | hit_j1);
            // cdb0 wins when both buses carry the same tag
            assign wake_vi[gi] = hit_i0 ? cdb0_val : cdb1_val;
            assign wake_vj[gi] = hit_j0 ? cdb0_val : cdb1_val;
        end
    endgenerate

    // Lowest-index ready entry (issue) and lowest-index free entry (dispatch)
    logic             issue_valid;
    logic [IDX_W-1:0] issue_idx;
    logic [IDX_W-1:0] free_idx;

    always_comb begin
        issue_valid = 1'b0;
        issue_idx   = '0;
        free_idx    = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (ready[i]) begin
                issue_valid = 1'b1;
                issue_idx   = IDX_W'(i);
            end
            if (!busy_reg[i]) begin
                free_idx = IDX_W'(i);
            end
        end
    end

    assign full_out = &busy_reg;

    logic accept;
    assign accept = disp_valid & ~full_out & ~flush_in;

    // Dispatched operands can be satisfied by a broadcast in the same cycle
    logic        d_hit_i0, d_hit_i1, d_hit_j0, d_hit_j1;
    logic [31:0] d_vi, d_vj;
    logic        d_qi_busy, d_qj_busy;

    assign d_hit_i0  = disp_Qi_busy && cdb0_valid && (cdb0_tag == disp_Qi);
    assign d_hit_i1  = disp_Qi_busy && cdb1_valid && (cdb1_tag == disp_Qi);
    assign d_hit_j0  = disp_Qj_busy && cdb0_valid && (cdb0_tag == disp_Qj);
    assign d_hit_j1  = disp_Qj_busy && cdb1_valid && (cdb1_tag == disp_Qj);
    assign d_vi      = d_hit_i0 ? cdb0_val : (d_hit_i1 ? cdb1_val : disp_Vi);
    assign d_vj      = d_hit_j0 ? cdb0_val : (d_hit_j1 ? cdb1_val : disp_Vj);
    assign d_qi_busy = disp_Qi_busy & ~(d_hit_i0 | d_hit_i1);
    assign d_qj_busy = disp_Qj_busy & ~(d_hit_j0 | d_hit_j1);

    // Entry registers. Dispatch only targets a free entry, so it never
    // collides with issue or wake-up of the same index.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            busy_reg    <= '0;
            qi_busy_reg <= '0;
            qj_busy_reg <= '0;
        end else if (rdy_in) begin
            if (flush_in) begin
                busy_reg <= '0;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (accept && (free_idx == IDX_W'(i))) begin
                        busy_reg[i]    <= 1'b1;
                        op_reg[i]      <= disp_op;
                        vi_reg[i]      <= d_vi;
                        qi_reg[i]      <= disp_Qi;
                        qi_busy_reg[i] <= d_qi_busy;
                        vj_reg[i]      <= d_vj;
                        qj_reg[i]      <= disp_Qj;
                        qj_busy_reg[i] <= d_qj_busy;
                        imm_reg[i]     <= disp_imm;
                        rd_reg[i]      <= disp_rd;
                        pc_reg[i]      <= disp_pc;
                        itype_reg[i]   <= disp_itype;
                    end else begin
                        if (issue_valid && (issue_idx == IDX_W'(i))) begin
                            busy_reg[i] <= 1'b0;
                        end
                        if (wake_i[i]) begin
                            vi_reg[i]      <= wake_vi[i];
                            qi_busy_reg[i] <= 1'b0;
                        end
                        if (wake_j[i]) begin
                            vj_reg[i]      <= wake_vj[i];
                            qj_busy_reg[i] <= 1'b0;
                        end
                    end
                end
            end
        end
    end

    logic [31:0] issue_rd_ext;
    assign issue_rd_ext = 32'(rd_reg[issue_idx]);

    // Issue bundle and occupancy count
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            alu_op    <= '0;
            alu_Vi    <= '0;
            alu_Vj    <= '0;
            alu_imm   <= '0;
            alu_rd    <= '0;
            alu_pc    <= '0;
            alu_itype <= 1'b0;
            count_out <= '0;
        end else if (rdy_in) begin
            if (flush_in) begin
                alu_op    <= '0;
                count_out <= '0;
            end else begin
                if (issue_valid) begin
                    alu_op    <= op_reg[issue_idx];
                    alu_Vi    <= vi_reg[issue_idx];
                    alu_Vj    <= vj_reg[issue_idx];
                    alu_imm   <= imm_reg[issue_idx];
                    alu_rd    <= issue_rd_ext[4:0];
                    alu_pc    <= pc_reg[issue_idx];
                    alu_itype <= itype_reg[issue_idx];
                end else begin
                    alu_op <= '0;
                end
                count_out <= count_out + CNT_W'(accept) - CNT_W'(issue_valid);
            end
        end
    end

endmodule

// File: tb/tb_alu_rs_scheduler.sv
module tb_alu_rs_scheduler;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, flush_in;
    logic        disp_valid;
    logic [6:0]  disp_op;
    logic [31:0] disp_Vi, disp_Vj, disp_imm, disp_pc;
    logic [4:0]  disp_Qi, disp_Qj, disp_rd;
    logic        disp_Qi_busy, disp_Qj_busy, disp_itype;
    logic        cdb0_valid, cdb1_valid;
    logic [4:0]  cdb0_tag, cdb1_tag;
    logic [31:0] cdb0_val, cdb1_val;
    logic [6:0]  alu_op;
    logic [31:0] alu_Vi, alu_Vj, alu_imm, alu_pc;
    logic [4:0]  alu_rd;
    logic        alu_itype;
    logic        full_out;
    logic [3:0]  count_out;

    alu_rs_scheduler #(.RS_SIZE(8), .TAG_W(5)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .disp_valid(disp_valid), .disp_op(disp_op),
        .disp_Vi(disp_Vi), .disp_Qi(disp_Qi), .disp_Qi_busy(disp_Qi_busy),
        .disp_Vj(disp_Vj), .disp_Qj(disp_Qj), .disp_Qj_busy(disp_Qj_busy),
        .disp_imm(disp_imm), .disp_rd(disp_rd), .disp_pc(disp_pc), .disp_itype(disp_itype),
        .cdb0_valid(cdb0_valid), .cdb0_tag(cdb0_tag), .cdb0_val(cdb0_val),
        .cdb1_valid(cdb1_valid), .cdb1_tag(cdb1_tag), .cdb1_val(cdb1_val),
        .alu_op(alu_op), .alu_Vi(alu_Vi), .alu_Vj(alu_Vj), .alu_imm(alu_imm),
        .alu_rd(alu_rd), .alu_pc(alu_pc), .alu_itype(alu_itype),
        .full_out(full_out), .count_out(count_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [6:0]  op;
        logic [31:0] vi;
        logic [31:0] vj;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic        itype;
    } issue_t;

    typedef struct packed {
        // inputs
        logic [6:0]  op;
        logic [31:0] vi;
        logic [31:0] vj;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic        itype;
        // expected issue bundle
        logic [6:0]  exp_op;
        logic [31:0] exp_vi;
        logic [31:0] exp_vj;
        logic [4:0]  exp_rd;
    } vec_t;

    issue_t sb_q[$];
    int     total = 0;
    int     bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [6:0] op, input logic [31:0] vi, input logic [31:0] vj,
                            input logic [31:0] imm, input logic [4:0] rd, input logic [31:0] pc,
                            input logic it);
        issue_t e;
        e.op = op; e.vi = vi; e.vj = vj; e.imm = imm; e.rd = rd; e.pc = pc; e.itype = it;
        sb_q.push_back(e);
    endtask

    // One clock; any issue produced by an active edge is popped and compared
    task automatic step();
        bit     act;
        issue_t e;
        act = rdy_in && !rst_in && !flush_in;
        @(posedge clk_in);
        #1;
        if (act && alu_op != 7'd0) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected_issue: got op=%h, expected no issue", alu_op);
            end else begin
                e = sb_q.pop_front();
                check("sb_op",    32'(alu_op),    32'(e.op));
                check("sb_vi",    alu_Vi,         e.vi);
                check("sb_vj",    alu_Vj,         e.vj);
                check("sb_imm",   alu_imm,        e.imm);
                check("sb_rd",    32'(alu_rd),    32'(e.rd));
                check("sb_pc",    alu_pc,         e.pc);
                check("sb_itype", 32'(alu_itype), 32'(e.itype));
                $display("issue op=%h vi=%h vj=%h rd=%0d", alu_op, alu_Vi, alu_Vj, alu_rd);
            end
        end
    endtask

    task automatic set_disp(input logic [6:0] op, input logic [31:0] vi, input logic [4:0] qi,
                            input logic qib, input logic [31:0] vj, input logic [4:0] qj,
                            input logic qjb, input logic [31:0] imm, input logic [4:0] rd,
                            input logic [31:0] pc, input logic it);
        disp_valid = 1'b1; disp_op = op;
        disp_Vi = vi; disp_Qi = qi; disp_Qi_busy = qib;
        disp_Vj = vj; disp_Qj = qj; disp_Qj_busy = qjb;
        disp_imm = imm; disp_rd = rd; disp_pc = pc; disp_itype = it;
    endtask

    task automatic idle_inputs();
        rdy_in = 1'b1; flush_in = 1'b0; disp_valid = 1'b0;
        cdb0_valid = 1'b0; cdb1_valid = 1'b0;
    endtask

    task automatic bcast(input int bus, input logic [4:0] tag, input logic [31:0] val);
        if (bus == 0) begin
            cdb0_valid = 1'b1; cdb0_tag = tag; cdb0_val = val;
        end else begin
            cdb1_valid = 1'b1; cdb1_tag = tag; cdb1_val = val;
        end
    endtask

    localparam logic [6:0] ADD = 7'h01;
    localparam int NV = 6;
    vec_t vec [NV];

    initial begin
        vec[0] = '{op:7'h01, vi:32'd10,        vj:32'd20,        imm:32'd0,  rd:5'd1,  pc:32'h100, itype:1'b0,
                   exp_op:7'h01, exp_vi:32'd10,        exp_vj:32'd20,        exp_rd:5'd1};
        vec[1] = '{op:7'h02, vi:32'hFFFF_FFFF, vj:32'd1,         imm:32'd4,  rd:5'd2,  pc:32'h104, itype:1'b1,
                   exp_op:7'h02, exp_vi:32'hFFFF_FFFF, exp_vj:32'd1,         exp_rd:5'd2};
        vec[2] = '{op:7'h7F, vi:32'h8000_0000, vj:32'h7FFF_FFFF, imm:32'd8,  rd:5'd31, pc:32'h108, itype:1'b0,
                   exp_op:7'h7F, exp_vi:32'h8000_0000, exp_vj:32'h7FFF_FFFF, exp_rd:5'd31};
        vec[3] = '{op:7'h04, vi:32'd0,         vj:32'd0,         imm:32'hC,  rd:5'd0,  pc:32'h10C, itype:1'b1,
                   exp_op:7'h04, exp_vi:32'd0,         exp_vj:32'd0,         exp_rd:5'd0};
        vec[4] = '{op:7'h05, vi:32'hDEAD_BEEF, vj:32'hCAFE_F00D, imm:32'h10, rd:5'd16, pc:32'h110, itype:1'b0,
                   exp_op:7'h05, exp_vi:32'hDEAD_BEEF, exp_vj:32'hCAFE_F00D, exp_rd:5'd16};
        vec[5] = '{op:7'h40, vi:32'h1234_5678, vj:32'h9ABC_DEF0, imm:32'h14, rd:5'd9,  pc:32'h114, itype:1'b1,
                   exp_op:7'h40, exp_vi:32'h1234_5678, exp_vj:32'h9ABC_DEF0, exp_rd:5'd9};

        idle_inputs();
        set_disp(7'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        disp_valid = 1'b0;
        cdb0_tag = 0; cdb0_val = 0; cdb1_tag = 0; cdb1_val = 0;

        // Reset state
        rst_in = 1'b1;
        step(); step();
        rst_in = 1'b0;
        check("rst_op",    32'(alu_op),    32'd0);
        check("rst_count", 32'(count_out), 32'd0);
        check("rst_full",  32'(full_out),  32'd0);
        check("rst_vi",    alu_Vi,         32'd0);
        check("rst_vj",    alu_Vj,         32'd0);
        check("rst_imm",   alu_imm,        32'd0);
        check("rst_pc",    alu_pc,         32'd0);
        check("rst_rd",    32'(alu_rd),    32'd0);
        check("rst_itype", 32'(alu_itype), 32'd0);

        // Ready ADD: dispatch at edge 1, issue after edge 2, idle after edge 3
        set_disp(ADD, 32'd5, 0, 0, 32'd7, 0, 0, 32'd0, 5'd3, 32'h40, 1'b0);
        push_exp(ADD, 32'd5, 32'd7, 32'd0, 5'd3, 32'h40, 1'b0);
        step();
        disp_valid = 1'b0;
        check("add_latency_op", 32'(alu_op), 32'd0);
        check("add_count1", 32'(count_out), 32'd1);
        step();
        check("add_op", 32'(alu_op), 32'(ADD));
        check("add_vi", alu_Vi, 32'd5);
        check("add_vj", alu_Vj, 32'd7);
        check("add_rd", 32'(alu_rd), 32'd3);
        check("add_count0", 32'(count_out), 32'd0);
        step();
        check("add_idle", 32'(alu_op), 32'd0);

        // Back-to-back ready dispatches from the vector table
        for (int i = 0; i < NV; i++) begin
            set_disp(vec[i].op, vec[i].vi, 0, 0, vec[i].vj, 0, 0, vec[i].imm, vec[i].rd, vec[i].pc, vec[i].itype);
            push_exp(vec[i].exp_op, vec[i].exp_vi, vec[i].exp_vj, vec[i].imm, vec[i].exp_rd, vec[i].pc, vec[i].itype);
            step();
            check("vec_count", 32'(count_out), 32'd1);
        end
        disp_valid = 1'b0;
        step();
        check("vec_last_op", 32'(alu_op), 32'(vec[NV-1].exp_op));
        check("vec_last_vi", alu_Vi, vec[NV-1].exp_vi);
        step();
        check("vec_end_op", 32'(alu_op), 32'd0);
        check("vec_end_count", 32'(count_out), 32'd0);

        // Wake via cdb1 two cycles after dispatch; issue one edge after broadcast
        set_disp(7'h02, 32'hBAD, 5'd9, 1'b1, 32'd3, 0, 0, 32'd1, 5'd4, 32'h200, 1'b1);
        step();
        disp_valid = 1'b0;
        step();
        check("wake_wait_op", 32'(alu_op), 32'd0);
        bcast(1, 5'd9, 32'h20);
        push_exp(7'h02, 32'h20, 32'd3, 32'd1, 5'd4, 32'h200, 1'b1);
        step();
        cdb1_valid = 1'b0;
        check("wake_no_same_edge", 32'(alu_op), 32'd0);
        step();
        check("wake_op", 32'(alu_op), 32'h02);
        check("wake_vi", alu_Vi, 32'h20);

        // Same tag on both buses: cdb0 value wins
        set_disp(7'h03, 0, 5'd10, 1'b1, 0, 5'd10, 1'b1, 32'd0, 5'd5, 32'h300, 1'b0);
        step();
        disp_valid = 1'b0;
        bcast(0, 5'd10, 32'hAA);
        bcast(1, 5'd10, 32'hBB);
        push_exp(7'h03, 32'hAA, 32'hAA, 32'd0, 5'd5, 32'h300, 1'b0);
        step();
        idle_inputs();
        step();
        check("prio_vj", alu_Vj, 32'hAA);

        // Operand satisfied by a broadcast in the dispatch cycle
        set_disp(7'h06, 32'hBAD, 5'd11, 1'b1, 32'd9, 0, 0, 32'd2, 5'd6, 32'h400, 1'b0);
        bcast(0, 5'd11, 32'h77);
        push_exp(7'h06, 32'h77, 32'd9, 32'd2, 5'd6, 32'h400, 1'b0);
        step();
        idle_inputs();
        step();
        check("dispcap_op", 32'(alu_op), 32'h06);
        check("dispcap_vi", alu_Vi, 32'h77);
        step();

        // Fill all eight entries with waiting operands (entry i waits on tag 16+i)
        for (int i = 0; i < 8; i++) begin
            set_disp(7'(8'h10 + i), 0, 5'(16 + i), 1'b1, 32'(i), 0, 0, 32'(i), 5'(i), 32'(32'h1000 + 4 * i), 1'(i));
            step();
        end
        check("fill_full", 32'(full_out), 32'd1);
        check("fill_count", 32'(count_out), 32'd8);
        set_disp(7'h18, 0, 5'd24, 1'b1, 0, 0, 0, 0, 5'd8, 32'h2000, 1'b0);
        step();
        disp_valid = 1'b0;
        check("full_ignore_count", 32'(count_out), 32'd8);
        check("full_ignore_full", 32'(full_out), 32'd1);
        bcast(0, 5'd16, 32'h100);
        push_exp(7'h10, 32'h100, 32'd0, 32'd0, 5'd0, 32'h1000, 1'b0);
        step();
        cdb0_valid = 1'b0;
        check("wake_full_still", 32'(full_out), 32'd1);
        step();
        check("drain_full", 32'(full_out), 32'd0);
        check("drain_count", 32'(count_out), 32'd7);

        // Entries 2 and 5 woken on the same edge: 2 first, then 5
        bcast(0, 5'd18, 32'h2);
        bcast(1, 5'd21, 32'h5);
        push_exp(7'h12, 32'h2, 32'd2, 32'd2, 5'd2, 32'h1008, 1'b0);
        push_exp(7'h15, 32'h5, 32'd5, 32'd5, 5'd5, 32'h1014, 1'b1);
        step();
        idle_inputs();
        step();
        check("order_first", 32'(alu_op), 32'h12);
        step();
        check("order_second", 32'(alu_op), 32'h15);
        step();
        check("order_idle", 32'(alu_op), 32'd0);
        check("order_count", 32'(count_out), 32'd5);

        // Issue entry 1 to leave four entries, then flush with a dispatch
        bcast(0, 5'd17, 32'h1);
        push_exp(7'h11, 32'h1, 32'd1, 32'd1, 5'd1, 32'h1004, 1'b1);
        step();
        idle_inputs();
        step();
        check("preflush_count", 32'(count_out), 32'd4);
        flush_in = 1'b1;
        set_disp(7'h30, 32'd1, 0, 0, 32'd2, 0, 0, 0, 5'd7, 32'h3000, 1'b0);
        step();
        idle_inputs();
        check("flush_count", 32'(count_out), 32'd0);
        check("flush_op", 32'(alu_op), 32'd0);
        check("flush_full", 32'(full_out), 32'd0);
        bcast(0, 5'd19, 32'h9); bcast(1, 5'd20, 32'h9);
        step();
        bcast(0, 5'd22, 32'h9); bcast(1, 5'd23, 32'h9);
        step();
        bcast(0, 5'd24, 32'h9);
        step();
        idle_inputs();
        step();
        check("flush_no_issue", 32'(alu_op), 32'd0);
        check("flush_count_after", 32'(count_out), 32'd0);

        // Pause: no issue, no capture, no dispatch, flush ignored
        set_disp(7'h40, 0, 5'd12, 1'b1, 32'd3, 0, 0, 0, 5'd6, 32'h500, 1'b0);
        step();
        set_disp(7'h41, 32'd1, 0, 0, 32'd2, 0, 0, 0, 5'd7, 32'h504, 1'b1);
        step();
        check("pause_pre_count", 32'(count_out), 32'd2);
        rdy_in = 1'b0; flush_in = 1'b1;
        set_disp(7'h42, 32'd4, 0, 0, 32'd4, 0, 0, 0, 5'd8, 32'h508, 1'b0);
        bcast(0, 5'd12, 32'h99);
        for (int i = 0; i < 3; i++) begin
            step();
            check("pause_op", 32'(alu_op), 32'd0);
            check("pause_count", 32'(count_out), 32'd2);
        end
        idle_inputs();
        push_exp(7'h41, 32'd1, 32'd2, 32'd0, 5'd7, 32'h504, 1'b1);
        step();
        check("resume_op", 32'(alu_op), 32'h41);
        rdy_in = 1'b0;
        step();
        check("pause_hold_op", 32'(alu_op), 32'h41);
        rdy_in = 1'b1;
        step();
        check("resume_no_capture", 32'(alu_op), 32'd0);
        bcast(0, 5'd12, 32'h44);
        push_exp(7'h40, 32'h44, 32'd3, 32'd0, 5'd6, 32'h500, 1'b0);
        step();
        idle_inputs();
        step();
        check("resume_late_vi", alu_Vi, 32'h44);
        step();
        check("resume_count", 32'(count_out), 32'd0);

        // Reset mid-operation overrides pause and dispatch
        set_disp(7'h50, 0, 5'd13, 1'b1, 0, 0, 0, 0, 5'd1, 32'h600, 1'b0);
        step();
        set_disp(7'h51, 0, 5'd14, 1'b1, 0, 0, 0, 0, 5'd2, 32'h604, 1'b0);
        step();
        check("prerst_count", 32'(count_out), 32'd2);
        rst_in = 1'b1; rdy_in = 1'b0;
        set_disp(7'h52, 32'd1, 0, 0, 32'd1, 0, 0, 0, 5'd3, 32'h608, 1'b0);
        step();
        check("midrst_count", 32'(count_out), 32'd0);
        check("midrst_op", 32'(alu_op), 32'd0);
        check("midrst_vi", alu_Vi, 32'd0);
        check("midrst_pc", alu_pc, 32'd0);
        check("midrst_full", 32'(full_out), 32'd0);
        rst_in = 1'b0;
        idle_inputs();
        bcast(0, 5'd13, 32'h1); bcast(1, 5'd14, 32'h2);
        step();
        idle_inputs();
        step();
        check("midrst_no_issue", 32'(alu_op), 32'd0);

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
